clk_tick_gen: RTL and testbench
===============================

Name: clk_tick_gen

Overview:
- Parametrised multi-channel successor to the single fixed clock divider.
- Generates NUM_CH independent, runtime-programmable divided outputs from the 100 MHz system clock.
- Each channel produces:
  - a one-cycle tick enable, for clock-enabling downstream logic, and
  - a near-50% square wave, for LEDs and scan.
- Sits between the board clock and the display/counter/FSM blocks, replacing per-block hard-coded dividers.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- CNT_W, 24, counter and divisor width in bits.
- DEFAULT_DIV, 10000000, per-channel divisor loaded at reset (0.1 s period at 100 MHz); must fit in CNT_W.
- CH_W, $clog2(NUM_CH) min 1, channel-select width (localparam, not overridable).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global count enable; low freezes every channel.
- cfg_we  in  1  one-cycle write strobe for a new divisor.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new divisor D.
- cfg_ack  out  1  one-cycle pulse: write accepted.
- cfg_err  out  1  one-cycle pulse: write rejected (cfg_ch >= NUM_CH).
- tick  out  NUM_CH  per-channel one-cycle pulse, once per period.
- sq  out  NUM_CH  per-channel square wave.

Behaviour:

Reset (rst high, asynchronous):
- All counters 0.
- Active divisor and shadow divisor both = DEFAULT_DIV.
- No pending update.
- tick = 0, sq = all ones, cfg_ack = 0, cfg_err = 0.

Counting (per channel, active divisor D >= 2, en high):
- cnt runs 0..D-1, then wraps to 0.
- Counter width is CNT_W; no overflow is possible since D <= 2^CNT_W - 1.

Tick:
- Registered.
- tick[i] = 1 for exactly the cycle following the edge on which cnt wrapped D-1 -> 0.
- First tick appears after the D-th rising edge following reset release (en high throughout).
- Period is exactly D cycles.

Square wave:
- Registered.
- sq[i] = 1 while cnt < ceil(D/2), else 0; odd D gives high for (D+1)/2 cycles.

Divisor special values:
- D = 0: channel disabled. cnt held 0, tick 0, sq 0.
- D = 1: treated as D = 2.

en low:
- All cnt frozen, tick forced 0, sq holds its last value.
- Pending updates remain pending.

Configuration write:
- On cfg_we with valid cfg_ch:
  - cfg_div goes to that channel's shadow register and the pending flag is set.
  - cfg_ack pulses the next cycle.
- Invalid cfg_ch:
  - No state change.
  - cfg_err pulses the next cycle; cfg_ack stays 0.
- Write while already pending: shadow is overwritten; the last write wins.

Applying an update:
- Glitch-free: shadow is copied to active on the same edge the counter wraps to 0, and the pending flag clears.
- The new period starts immediately after that wrap; no truncated or stretched period is ever emitted.
- If the active divisor is 0 (disabled), the shadow applies on the next edge regardless of en, and cnt restarts at 0.
- A write to 0 on a running channel takes effect at the next wrap; the channel then goes idle.

Reset mid-operation:
- All outputs return to reset values asynchronously.
- Pending writes are discarded.

Optional Feature:
- CLK_TICK_GEN_SYNC_EN
- Defined:
  - Adds input port sync (1 bit).
  - A sync pulse forces every channel's cnt to 0 on the next edge and applies any pending shadows at once.
  - This phase-aligns all channels.
  - Takes priority over the normal wrap; works even with en low (the counter still freezes at 0 afterwards).
- Undefined: port absent; channels are never forcibly realigned.

Decomposition:
- Shared package/include clk_tick_pkg:
  - DEFAULT_DIV_100MS = 10000000
  - DIV_1MS = 100000
  - CNT_W default
  - tick_w width macro shared by consumers
- One natural sub-module: clk_tick_ch.
  - Contents: counter, active/shadow divisor, pending flag, tick/sq registers for a single channel.
  - Instantiated NUM_CH times in a generate loop.
  - Top level holds only cfg decode and the ack/err pulses.

Test Plan:
1. Simulation build NUM_CH=2, CNT_W=8, DEFAULT_DIV=4; release rst, en=1 -> tick[0] high at edges 4, 8, 12 (one cycle each); sq[0] pattern 1,1,0,0 repeating.
2. Write ch1 D=5 mid-period at cnt=2 -> cfg_ack next cycle; old period of 4 completes, then 5-cycle periods follow; sq[1] high for 3 cycles, low for 2; no short pulse.
3. Write ch1 D=0, then D=6 three cycles later -> ch1 goes idle (tick 0, sq 0) after the wrap; D=6 applies next edge and the first tick arrives 6 cycles later.
4. Write cfg_ch=3 with NUM_CH=2 -> cfg_err single pulse, cfg_ack 0, both channels unchanged.
5. Drop en for 10 cycles at cnt=1 -> no ticks during that window; sq frozen; counting resumes from cnt=1 and the next tick comes 3 cycles after en returns.
6. Assert rst asynchronously mid-cycle with a write pending -> outputs reset immediately; the pending write is lost and the divisor reads back as DEFAULT_DIV (period 4). With CLK_TICK_GEN_SYNC_EN defined: a sync pulse gives simultaneous ticks on both channels one period later.

Source files
------------

// File: rtl/clk_tick_pkg.sv
// clk_tick_pkg: shared constants and helpers for the tick generator
// and its consumers (default divisors, counter width, TICK_W macro).
`ifndef TICK_W
`define TICK_W(n) ((n) < 1 ? 1 : (n))
`endif

package clk_tick_pkg;

    // 0.1 s and 1 ms periods at the 100 MHz board clock
    localparam int unsigned DEFAULT_DIV_100MS = 10000000;
    localparam int unsigned DIV_1MS           = 100000;
    localparam int          CNT_W_DEF         = 24;

    // channel-select width, never narrower than one bit
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_tick_ch.sv
// clk_tick_ch: one divider channel (counter, active/shadow divisor,
// pending flag, registered tick and square wave).
// Ports: clk, rst (async high), en, sync, wr/wr_div (shadow write),
// tick (one-cycle pulse per period), sq (near-50% square wave).
module clk_tick_ch
    import clk_tick_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             sq
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] div_act, act_n;
    logic [CNT_W-1:0] div_sh, sh_n;
    logic             pend, pend_n;
    logic             tick_n, sq_n;
    logic [CNT_W-1:0] d_eff;
    logic             wrap;

    // ceil(d/2) without overflowing at the maximum divisor
    function automatic logic [CNT_W-1:0] half(input logic [CNT_W-1:0] d);
        return (d >> 1) + CNT_W'(d[0]);
    endfunction

    always_comb begin
        d_eff  = (div_act == ONE) ? TWO : div_act;
        wrap   = (cnt == d_eff - ONE);
        cnt_n  = cnt;
        act_n  = div_act;
        sh_n   = div_sh;
        pend_n = pend;
        tick_n = 1'b0;
        sq_n   = sq;
        // sync realigns; an idle channel loads its shadow regardless of en
        if (sync || div_act == '0) begin
            cnt_n = '0;
            if (pend) begin
                act_n  = div_sh;
                pend_n = 1'b0;
            end
            sq_n = (cnt_n < half(act_n));
        end else if (en) begin
            if (wrap) begin
                cnt_n  = '0;
                tick_n = 1'b1;
                // new divisor only at the wrap, so periods stay whole
                if (pend) begin
                    act_n  = div_sh;
                    pend_n = 1'b0;
                end
            end else begin
                cnt_n = cnt + ONE;
            end
            sq_n = (cnt_n < half(act_n));
        end
        // a write in the same cycle as an apply stays pending
        if (wr) begin
            sh_n   = wr_div;
            pend_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            div_sh  <= DIV_RST;
            pend    <= 1'b0;
            tick    <= 1'b0;
            sq      <= 1'b1;
        end else begin
            cnt     <= cnt_n;
            div_act <= act_n;
            div_sh  <= sh_n;
            pend    <= pend_n;
            tick    <= tick_n;
            sq      <= sq_n;
        end
    end

endmodule

// File: rtl/clk_tick_gen.sv
// clk_tick_gen: NUM_CH programmable tick/square-wave dividers.
// Ports: clk, rst (async high), en, cfg_we/cfg_ch/cfg_div write port,
// cfg_ack/cfg_err result pulses, tick[NUM_CH], sq[NUM_CH].
// CLK_TICK_GEN_SYNC_EN adds input sync to phase-align all channels.
module clk_tick_gen
    import clk_tick_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_100MS,
    localparam int         CH_W        = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef CLK_TICK_GEN_SYNC_EN
    input  logic              sync,
`endif
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

`ifndef CLK_TICK_GEN_SYNC_EN
    logic sync;
    assign sync = 1'b0;
`endif

    logic              ch_valid;
    logic [NUM_CH-1:0] wr;

    // non-power-of-two NUM_CH leaves unused select codes
    assign ch_valid = (32'(cfg_ch) < NUM_CH);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = cfg_we & ch_valid & (cfg_ch == CH_W'(i));

        clk_tick_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en),
            .sync   (sync),
            .wr     (wr[i]),
            .wr_div (cfg_div),
            .tick   (tick[i]),
            .sq     (sq[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_we & ch_valid;
            cfg_err <= cfg_we & ~ch_valid;
        end
    end

endmodule

// File: tb/tb_clk_tick_gen.sv
// tb_clk_tick_gen: directed vector bench for clk_tick_gen
// (NUM_CH=2, CNT_W=8, DEFAULT_DIV=4; plus a 3-channel copy).
module tb_clk_tick_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [0:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       cfg_ack, cfg_err;
    logic [1:0] tick, sq;

    logic       en3 = 1'b1;
    logic       c3_we = 1'b0;
    logic [1:0] c3_ch = '0;
    logic [7:0] c3_div = '0;
    logic       c3_ack, c3_err;
    logic [2:0] tick3, sq3;

`ifdef CLK_TICK_GEN_SYNC_EN
    logic sync = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_tick_gen #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef CLK_TICK_GEN_SYNC_EN
        .sync    (sync),
`endif
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err),
        .tick    (tick),
        .sq      (sq)
    );

    clk_tick_gen #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .en      (en3),
`ifdef CLK_TICK_GEN_SYNC_EN
        .sync    (1'b0),
`endif
        .cfg_we  (c3_we),
        .cfg_ch  (c3_ch),
        .cfg_div (c3_div),
        .cfg_ack (c3_ack),
        .cfg_err (c3_err),
        .tick    (tick3),
        .sq      (sq3)
    );

    typedef struct {
        logic       en;
        logic       we;
        logic [0:0] ch;
        logic [7:0] div;
        logic [1:0] tick;
        logic [1:0] sq;
        logic       ack;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic e, input logic w,
                                input logic [0:0] c, input logic [7:0] d,
                                input logic [1:0] t, input logic [1:0] s,
                                input logic a);
        vec_t v;
        v.en = e; v.we = w; v.ch = c; v.div = d;
        v.tick = t; v.sq = s; v.ack = a;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // two D=4 channels, then ch1 -> 5, ch1 -> 0, ch1 -> 6, en low
        add(1,0,0,0, 2'b00,2'b11,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b11,2'b11,0);
        add(1,0,0,0, 2'b00,2'b11,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,1,1,5, 2'b00,2'b00,1);
        add(1,0,0,0, 2'b11,2'b11,0);
        add(1,0,0,0, 2'b00,2'b11,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b01,2'b01,0);
        add(1,0,0,0, 2'b10,2'b11,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b01,2'b01,0);
        add(1,0,0,0, 2'b00,2'b01,0);
        add(1,0,0,0, 2'b10,2'b10,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b01,2'b11,0);
        add(1,0,0,0, 2'b00,2'b01,0);
        add(1,1,1,0, 2'b00,2'b00,1);
        add(1,0,0,0, 2'b10,2'b00,0);
        add(1,0,0,0, 2'b01,2'b01,0);
        add(1,1,1,6, 2'b00,2'b01,1);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b01,2'b11,0);
        add(1,0,0,0, 2'b00,2'b01,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b11,2'b11,0);
        add(1,0,0,0, 2'b00,2'b11,0);
        for (int k = 0; k < 10; k++) add(0,0,0,0, 2'b00,2'b11,0);
        add(1,0,0,0, 2'b00,2'b10,0);
        add(1,0,0,0, 2'b00,2'b00,0);
        add(1,0,0,0, 2'b01,2'b01,0);

        #1 rst = 1'b1;
        #2;
        check("reset tick", 8'(tick), 8'h00);
        check("reset sq", 8'(sq), 8'h03);
        check("reset ack", 8'(cfg_ack), 8'h00);
        check("reset err", 8'(cfg_err), 8'h00);
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            en = vecs[i].en;
            cfg_we = vecs[i].we;
            cfg_ch = vecs[i].ch;
            cfg_div = vecs[i].div;
            @(posedge clk);
            #1;
            check($sformatf("v%0d tick", i), 8'(tick), 8'(vecs[i].tick));
            check($sformatf("v%0d sq", i), 8'(sq), 8'(vecs[i].sq));
            check($sformatf("v%0d ack", i), 8'(cfg_ack), 8'(vecs[i].ack));
            check($sformatf("v%0d err", i), 8'(cfg_err), 8'h00);
            @(negedge clk);
        end
        cfg_we = 1'b0;

        // out-of-range channel on the 3-channel copy
        c3_we = 1'b1; c3_ch = 2'd3; c3_div = 8'd9;
        @(posedge clk); #1;
        check("bad ch err", 8'(c3_err), 8'h01);
        check("bad ch ack", 8'(c3_ack), 8'h00);
        @(negedge clk) c3_we = 1'b0;
        @(posedge clk); #1;
        check("err one pulse", 8'(c3_err), 8'h00);
        @(negedge clk);
        c3_we = 1'b1; c3_ch = 2'd2; c3_div = 8'd4;
        @(posedge clk); #1;
        check("ch2 ack", 8'(c3_ack), 8'h01);
        check("ch2 no err", 8'(c3_err), 8'h00);
        @(negedge clk) c3_we = 1'b0;
        ok = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(posedge clk); #1;
            if (tick3 != 3'b000) ok = 1;
        end
        check("dut3 tick seen", 8'(ok), 8'h01);
        check("dut3 tick all", 8'(tick3), 8'h07);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("dut3 period e%0d", k), 8'(tick3),
                  (k == 4) ? 8'h07 : 8'h00);
        end

        // pending write lost on async reset mid-cycle
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_div = 8'd7;
        @(posedge clk); #1;
        check("pre-rst ack", 8'(cfg_ack), 8'h01);
        #2 rst = 1'b1; cfg_we = 1'b0;
        #1;
        check("async rst tick", 8'(tick), 8'h00);
        check("async rst sq", 8'(sq), 8'h03);
        check("async rst ack", 8'(cfg_ack), 8'h00);
        @(negedge clk) rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("post-rst tick e%0d", k), 8'(tick),
                  (k % 4 == 0) ? 8'h03 : 8'h00);
            check($sformatf("post-rst sq e%0d", k), 8'(sq),
                  (k % 4 < 2) ? 8'h03 : 8'h00);
        end

`ifdef CLK_TICK_GEN_SYNC_EN
        // skew ch1 with D=3, queue D=4, then realign with sync
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd3;
        @(posedge clk); #1;
        check("sync pre ack", 8'(cfg_ack), 8'h01);
        @(negedge clk) cfg_we = 1'b0;
        ok = 0;
        for (int k = 0; k < 12 && !ok; k++) begin
            @(posedge clk); #1;
            if (tick[1]) ok = 1;
        end
        check("ch1 d3 applied", 8'(ok), 8'h01);
        @(negedge clk);
        cfg_we = 1'b1; cfg_ch = 1'b1; cfg_div = 8'd4;
        @(posedge clk); #1;
        @(negedge clk) cfg_we = 1'b0; sync = 1'b1;
        @(posedge clk); #1;
        check("sync edge tick", 8'(tick), 8'h00);
        check("sync edge sq", 8'(sq), 8'h03);
        @(negedge clk) sync = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("sync tick e%0d", k), 8'(tick),
                  (k == 4) ? 8'h03 : 8'h00);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
